// File: rtl/dma_scheduler.sv
// DMA descriptor scheduler: per-requester descriptor FIFOs, round-robin grant, one copy job in flight.
// Define DMA_SCHED_STATS_EN to build the stat_jobs / stat_busy counters (tied to zero otherwise).
module dma_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int Q_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [64*NUM_REQ-1:0]      req_src,
  input  logic [64*NUM_REQ-1:0]      req_dst,
  input  logic [32*NUM_REQ-1:0]      req_len,
  input  logic [NUM_REQ-1:0]         req_src_res,
  input  logic [NUM_REQ-1:0]         req_dst_res,
  input  logic [8*NUM_REQ-1:0]       req_tag,
  output logic                       dma_start,
  output logic [63:0]                dma_src,
  output logic [63:0]                dma_dst,
  output logic [31:0]                dma_len,
  output logic                       dma_src_res,
  output logic                       dma_dst_res,
  input  logic                       dma_done,
  output logic                       cmp_valid,
  input  logic                       cmp_ready,
  output logic [$clog2(NUM_REQ)-1:0] cmp_id,
  output logic [7:0]                 cmp_tag,
  output logic                       cmp_err,
  output logic [31:0]                stat_jobs,
  output logic [31:0]                stat_busy
);
  localparam int          IDW = $clog2(NUM_REQ);
  localparam int          AW  = $clog2(Q_DEPTH);
  localparam int          CW  = AW + 1;
  localparam int unsigned NRU = NUM_REQ;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CMPL} state_t;
  state_t r_state, w_state_nxt;

  logic [63:0]        r_q_src  [NUM_REQ][Q_DEPTH];
  logic [63:0]        r_q_dst  [NUM_REQ][Q_DEPTH];
  logic [31:0]        r_q_len  [NUM_REQ][Q_DEPTH];
  logic               r_q_sres [NUM_REQ][Q_DEPTH];
  logic               r_q_dres [NUM_REQ][Q_DEPTH];
  logic [7:0]         r_q_tag  [NUM_REQ][Q_DEPTH];
  logic [AW-1:0]      r_wr  [NUM_REQ];
  logic [AW-1:0]      r_rd  [NUM_REQ];
  logic [AW:0]        r_cnt [NUM_REQ];

  logic [NUM_REQ-1:0] w_push, w_pop, w_nempty;
  logic               w_any, w_hs;
  logic [IDW-1:0]     w_gnt, w_cand, w_rr_nxt, r_rr_ptr;

  logic [63:0]        r_job_src, r_job_dst;
  logic [31:0]        r_job_len;
  logic               r_job_sres, r_job_dres;
  logic [7:0]         r_job_tag;
  logic [IDW-1:0]     r_job_id;
  logic [1:0]         r_wait_cnt;
  logic               r_cmp_err;

  always_comb begin
    req_ready = '0;
    w_nempty  = '0;
    w_push    = '0;
    for (int unsigned i = 0; i < NRU; i++) begin
      req_ready[i] = (r_cnt[i] != CW'(Q_DEPTH));
      w_nempty[i]  = (r_cnt[i] != '0);
      w_push[i]    = req_valid[i] & req_ready[i];
    end
  end

  // First non-empty queue scanning upward from r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = '0;
    w_cand = '0;
    for (int unsigned k = 0; k < NRU; k++) begin
      w_cand = IDW'((32'(r_rr_ptr) + k) % NRU);
      if (!w_any && w_nempty[w_cand]) begin
        w_any = 1'b1;
        w_gnt = w_cand;
      end
    end
    w_pop = '0;
    if (r_state == IDLE && w_any) w_pop[w_gnt] = 1'b1;
  end

  assign w_hs     = (r_state == CMPL) && cmp_ready;
  assign w_rr_nxt = (r_job_id == IDW'(NUM_REQ - 1)) ? '0 : r_job_id + IDW'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = (r_job_sres && r_job_dres) ? WAIT : CMPL;
      WAIT:    if (r_wait_cnt == 2'd2 && dma_done) w_state_nxt = CMPL;
      CMPL:    if (cmp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NRU; i++) begin
      if (w_push[i]) begin
        r_q_src[i][r_wr[i]]  <= req_src[64*i +: 64];
        r_q_dst[i][r_wr[i]]  <= req_dst[64*i +: 64];
        r_q_len[i][r_wr[i]]  <= req_len[32*i +: 32];
        r_q_sres[i][r_wr[i]] <= req_src_res[i];
        r_q_dres[i][r_wr[i]] <= req_dst_res[i];
        r_q_tag[i][r_wr[i]]  <= req_tag[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_job_src  <= '0;
      r_job_dst  <= '0;
      r_job_len  <= '0;
      r_job_sres <= 1'b0;
      r_job_dres <= 1'b0;
      r_job_tag  <= '0;
      r_job_id   <= '0;
      r_wait_cnt <= '0;
      r_cmp_err  <= 1'b0;
      for (int unsigned i = 0; i < NRU; i++) begin
        r_wr[i]  <= '0;
        r_rd[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      for (int unsigned i = 0; i < NRU; i++) begin
        if (w_push[i]) r_wr[i] <= r_wr[i] + AW'(1);
        if (w_pop[i])  r_rd[i] <= r_rd[i] + AW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
      if (r_state == IDLE && w_any) begin
        r_job_src  <= r_q_src[w_gnt][r_rd[w_gnt]];
        r_job_dst  <= r_q_dst[w_gnt][r_rd[w_gnt]];
        r_job_len  <= r_q_len[w_gnt][r_rd[w_gnt]];
        r_job_sres <= r_q_sres[w_gnt][r_rd[w_gnt]];
        r_job_dres <= r_q_dres[w_gnt][r_rd[w_gnt]];
        r_job_tag  <= r_q_tag[w_gnt][r_rd[w_gnt]];
        r_job_id   <= w_gnt;
      end
      // The WAIT counter saturates at 2 so a done level left over from the previous job is masked.
      if (r_state == ISSUE) begin
        r_wait_cnt <= '0;
        r_cmp_err  <= ~(r_job_sres & r_job_dres);
      end else if (r_state == WAIT && r_wait_cnt != 2'd2) begin
        r_wait_cnt <= r_wait_cnt + 2'd1;
      end
      if (w_hs) r_rr_ptr <= w_rr_nxt;
    end
  end

  assign dma_start   = (r_state == ISSUE) && r_job_sres && r_job_dres;
  assign dma_src     = r_job_src;
  assign dma_dst     = r_job_dst;
  assign dma_len     = r_job_len;
  assign dma_src_res = r_job_sres;
  assign dma_dst_res = r_job_dres;
  assign cmp_valid   = (r_state == CMPL);
  assign cmp_id      = r_job_id;
  assign cmp_tag     = r_job_tag;
  assign cmp_err     = r_cmp_err;

`ifdef DMA_SCHED_STATS_EN
  logic [31:0] r_stat_jobs, r_stat_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_jobs <= '0;
      r_stat_busy <= '0;
    end else begin
      if (w_hs)             r_stat_jobs <= r_stat_jobs + 32'd1;
      if (r_state != IDLE)  r_stat_busy <= r_stat_busy + 32'd1;
    end
  end

  assign stat_jobs = r_stat_jobs;
  assign stat_busy = r_stat_busy;
`else
  assign stat_jobs = '0;
  assign stat_busy = '0;
`endif
endmodule

// File: tb/tb_dma_scheduler.sv
// Bench for dma_scheduler: a queue-based job model checked every cycle, plus directed scenarios
// with hand-computed timing, ordering and status expectations.
module tb_dma_scheduler;
  localparam int NR = 2;
  localparam int QD = 2;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_CMPL = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [64*NR-1:0] req_src = '0, req_dst = '0;
  logic [32*NR-1:0] req_len = '0;
  logic [NR-1:0]   req_src_res = '0, req_dst_res = '0;
  logic [8*NR-1:0] req_tag = '0;
  logic            dma_start;
  logic [63:0]     dma_src, dma_dst;
  logic [31:0]     dma_len;
  logic            dma_src_res, dma_dst_res;
  logic            dma_done = 1'b1;
  logic            cmp_valid;
  logic            cmp_ready = 1'b1;
  logic [$clog2(NR)-1:0] cmp_id;
  logic [7:0]      cmp_tag;
  logic            cmp_err;
  logic [31:0]     stat_jobs, stat_busy;

  always #5 clk = ~clk;

  dma_scheduler #(.NUM_REQ(NR), .Q_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
    .req_src_res(req_src_res), .req_dst_res(req_dst_res), .req_tag(req_tag),
    .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .dma_src_res(dma_src_res), .dma_dst_res(dma_dst_res), .dma_done(dma_done),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id), .cmp_tag(cmp_tag),
    .cmp_err(cmp_err), .stat_jobs(stat_jobs), .stat_busy(stat_busy)
  );

  int unsigned total = 0, bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen within cycle budget (cycle %0d)", name, cyc);
  endtask

  // Job-level model: queues of descriptors, a rotating preference and the current job.
  typedef struct {
    logic [63:0] src, dst;
    logic [31:0] len;
    logic        sres, dres;
    logic [7:0]  tag;
  } desc_t;

  desc_t       m_q [NR][$];
  desc_t       m_job;
  int          m_jid, m_rr, m_st, m_age;
  logic        m_err;
  int unsigned m_jobs, m_busy;
  bit          m_on = 0;

  task automatic model_step();
    logic [NR-1:0] rdy;
    bit found;
    int j;
    desc_t d;
    if (rst) begin
      for (int i = 0; i < NR; i++) m_q[i].delete();
      m_job = '{src: '0, dst: '0, len: '0, sres: 1'b0, dres: 1'b0, tag: '0};
      m_jid = 0; m_rr = 0; m_st = P_IDLE; m_age = 0; m_err = 1'b0;
      m_jobs = 0; m_busy = 0; m_on = 1;
    end else if (m_on) begin
      for (int i = 0; i < NR; i++) rdy[i] = (m_q[i].size() < QD);
      if (m_st != P_IDLE) m_busy++;
      case (m_st)
        P_IDLE: begin
          found = 0;
          for (int k = 0; k < NR; k++) begin
            j = (m_rr + k) % NR;
            if (!found && m_q[j].size() > 0) begin
              found = 1; m_job = m_q[j].pop_front(); m_jid = j; m_st = P_ISSUE;
            end
          end
        end
        P_ISSUE: begin
          m_err = !(m_job.sres && m_job.dres);
          m_st  = m_err ? P_CMPL : P_WAIT;
          m_age = 0;
        end
        P_WAIT:  if (m_age < 2) m_age++; else if (dma_done) m_st = P_CMPL;
        default: if (cmp_ready) begin m_st = P_IDLE; m_rr = (m_jid + 1) % NR; m_jobs++; end
      endcase
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && rdy[i]) begin
          d.src = req_src[64*i +: 64]; d.dst = req_dst[64*i +: 64];
          d.len = req_len[32*i +: 32]; d.sres = req_src_res[i];
          d.dres = req_dst_res[i]; d.tag = req_tag[8*i +: 8];
          m_q[i].push_back(d);
        end
      end
    end
  endtask

  logic [63:0] dut_starts[$];
  int unsigned last_start_cyc = 0, last_cmp_rise = 0;

  // Compare on the falling edge, then advance the model with the inputs the next rising edge sees.
  initial begin : compare
    logic prev_cmp;
    logic [NR-1:0] exp_rdy;
    logic [31:0] exp_sj, exp_sb;
    prev_cmp = 1'b0;
    forever begin
      @(negedge clk);
      if (m_on) begin
        for (int i = 0; i < NR; i++) exp_rdy[i] = (m_q[i].size() < QD);
`ifdef DMA_SCHED_STATS_EN
        exp_sj = m_jobs; exp_sb = m_busy;
`else
        exp_sj = '0; exp_sb = '0;
`endif
        chk("req_ready", req_ready, exp_rdy);
        chk("dma_start", dma_start, (m_st == P_ISSUE) && m_job.sres && m_job.dres);
        chk("cmp_valid", cmp_valid, m_st == P_CMPL);
        chk("cmp_id", cmp_id, m_jid);
        chk("cmp_tag", cmp_tag, m_job.tag);
        chk("cmp_err", cmp_err, m_err);
        chk("dma_src", dma_src, m_job.src);
        chk("dma_dst", dma_dst, m_job.dst);
        chk("dma_len", dma_len, m_job.len);
        chk("dma_src_res", dma_src_res, m_job.sres);
        chk("dma_dst_res", dma_dst_res, m_job.dres);
        chk("stat_jobs", stat_jobs, exp_sj);
        chk("stat_busy", stat_busy, exp_sb);
      end
      if (dma_start === 1'b1) begin
        dut_starts.push_back(dma_src);
        last_start_cyc = cyc;
      end
      if (cmp_valid === 1'b1 && !prev_cmp) last_cmp_rise = cyc;
      prev_cmp = (cmp_valid === 1'b1);
      #2;
      model_step();
    end
  end

  // Engine: mode 0 drops done at start and raises it 6 cycles later; mode 1 leaves done high;
  // mode 2 drops done and holds it low until the mode returns to 0.
  int eng_mode = 0;
  int eng_cnt = 0;
  always @(negedge clk) begin
    if (dma_start === 1'b1 && eng_mode != 1) begin
      dma_done = 1'b0;
      eng_cnt  = (eng_mode == 2) ? -1 : 6;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) dma_done = 1'b1;
    end else if (eng_cnt < 0 && eng_mode != 2) begin
      eng_cnt  = 0;
      dma_done = 1'b1;
    end
  end

  int unsigned t_push = 0;

  task automatic set_desc(input int i, input logic [63:0] s, input logic [63:0] d,
                          input logic [31:0] l, input logic sr, input logic dr, input logic [7:0] t);
    req_src[64*i +: 64] = s;
    req_dst[64*i +: 64] = d;
    req_len[32*i +: 32] = l;
    req_src_res[i] = sr;
    req_dst_res[i] = dr;
    req_tag[8*i +: 8] = t;
  endtask

  task automatic push1(input int i, input logic [63:0] s, input logic [63:0] d,
                       input logic [31:0] l, input logic sr, input logic dr, input logic [7:0] t);
    @(negedge clk);
    set_desc(i, s, d, l, sr, dr, t);
    req_valid = '0;
    req_valid[i] = 1'b1;
    t_push = cyc + 1;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_starts(input int unsigned n, input int unsigned lim, input string nm);
    bit ok;
    ok = 0;
    for (int unsigned c = 0; c < lim && !ok; c++) begin
      @(negedge clk); #1;
      if (dut_starts.size() >= n) ok = 1;
    end
    if (!ok) timeout(nm);
  endtask

  task automatic wait_cmp(input int unsigned lim, input string nm);
    bit ok;
    ok = 0;
    for (int unsigned c = 0; c < lim && !ok; c++) begin
      @(negedge clk); #1;
      if (cmp_valid === 1'b1) ok = 1;
    end
    if (!ok) timeout(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned n0, s0;
    logic pr, seen;
    logic [63:0] exp_order [4];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_req_ready", req_ready, 2'b11);
    chk("reset_cmp_valid", cmp_valid, 1'b0);
    chk("reset_dma_start", dma_start, 1'b0);

    // Single resident job, engine answers 6 cycles after start.
    n0 = dut_starts.size();
    push1(0, 64'h100, 64'h200, 32'd4, 1'b1, 1'b1, 8'h11);
    wait_starts(n0 + 1, 20, "single_start");
    chk("single_start_latency", last_start_cyc - t_push, 1);
    s0 = last_start_cyc;
    wait_cmp(30, "single_cmp");
    chk("single_cmp_delay", last_cmp_rise - s0, 7);
    chk("single_cmp_id", cmp_id, 0);
    chk("single_cmp_tag", cmp_tag, 8'h11);
    chk("single_cmp_err", cmp_err, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("single_one_pulse", dut_starts.size() - n0, 1);

    // Fairness: two descriptors per requester, rr pointer restarted by reset.
    do_reset();
    n0 = dut_starts.size();
    @(negedge clk);
    set_desc(0, 64'h1000, 64'h3000, 32'd0, 1'b1, 1'b1, 8'hA0);
    set_desc(1, 64'h2000, 64'h4000, 32'd8, 1'b1, 1'b1, 8'hB0);
    req_valid = 2'b11;
    @(negedge clk);
    set_desc(0, 64'h1001, 64'h3001, 32'd1, 1'b1, 1'b1, 8'hA1);
    set_desc(1, 64'h2001, 64'h4001, 32'd9, 1'b1, 1'b1, 8'hB1);
    @(negedge clk);
    req_valid = '0;
    wait_starts(n0 + 4, 120, "fair_starts");
    exp_order = '{64'h1000, 64'h2000, 64'h1001, 64'h2001};
    for (int k = 0; k < 4; k++)
      if (dut_starts.size() > n0 + k) chk($sformatf("fair_order_%0d", k), dut_starts[n0 + k], exp_order[k]);
    repeat (15) @(negedge clk);

    // Backpressure on requester 1 while requester 0's job stalls in WAIT.
    do_reset();
    eng_mode = 2;
    n0 = dut_starts.size();
    push1(0, 64'h500, 64'h600, 32'd2, 1'b1, 1'b1, 8'h30);
    wait_starts(n0 + 1, 20, "bp_first_start");
    set_desc(1, 64'h510, 64'h610, 32'd3, 1'b1, 1'b1, 8'h31);
    req_valid = 2'b10;
    @(negedge clk);
    #1;
    chk("bp_ready_after_push1", req_ready[1], 1'b1);
    set_desc(1, 64'h520, 64'h620, 32'd5, 1'b1, 1'b1, 8'h32);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("bp_ready_after_push2", req_ready[1], 1'b0);
    n0 = dut_starts.size();
    eng_mode = 0;
    pr = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk); #1;
      if (dut_starts.size() > n0) seen = 1'b1;
      else pr = req_ready[1];
    end
    if (!seen) timeout("bp_req1_start");
    else begin
      chk("bp_ready_before_pop", pr, 1'b0);
      chk("bp_ready_after_pop", req_ready[1], 1'b1);
      chk("bp_req1_src", dut_starts[n0], 64'h510);
    end
    repeat (30) @(negedge clk);

    // Non-resident destination: no start, error completion held until accepted.
    do_reset();
    cmp_ready = 1'b0;
    n0 = dut_starts.size();
    push1(0, 64'h700, 64'h800, 32'd6, 1'b1, 1'b0, 8'h22);
    wait_cmp(20, "nres_cmp");
    chk("nres_cmp_delay", last_cmp_rise - t_push, 2);
    chk("nres_err", cmp_err, 1'b1);
    chk("nres_tag", cmp_tag, 8'h22);
    repeat (3) @(negedge clk);
    #1;
    chk("nres_hold_valid", cmp_valid, 1'b1);
    chk("nres_hold_tag", cmp_tag, 8'h22);
    @(negedge clk);
    cmp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("nres_released", cmp_valid, 1'b0);
    chk("nres_no_start", dut_starts.size() - n0, 0);

    // Stale done: level already high at start must be ignored for two cycles.
    do_reset();
    eng_mode = 1;
    n0 = dut_starts.size();
    push1(1, 64'h900, 64'hA00, 32'd7, 1'b1, 1'b1, 8'h40);
    wait_starts(n0 + 1, 20, "stale_start");
    s0 = last_start_cyc;
    wait_cmp(20, "stale_cmp");
    chk("stale_cmp_delay", last_cmp_rise - s0, 4);
    repeat (3) @(negedge clk);

    // Reset while the job waits on the engine: job is abandoned silently.
    eng_mode = 2;
    n0 = dut_starts.size();
    push1(0, 64'hB00, 64'hC00, 32'd9, 1'b1, 1'b1, 8'h41);
    wait_starts(n0 + 1, 20, "rstw_start");
    repeat (2) @(negedge clk);
    do_reset();
    chk("rstw_dma_start", dma_start, 1'b0);
    chk("rstw_dma_src", dma_src, 64'h0);
    chk("rstw_dma_dst", dma_dst, 64'h0);
    chk("rstw_dma_len", dma_len, 32'h0);
    chk("rstw_res", {dma_src_res, dma_dst_res}, 2'b00);
    chk("rstw_cmp", {cmp_valid, cmp_err, cmp_tag}, 10'h0);
    chk("rstw_req_ready", req_ready, 2'b11);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (cmp_valid !== 1'b0) seen = 1'b1;
    end
    chk("rstw_no_cmp", seen, 1'b0);
    eng_mode = 0;
    repeat (3) @(negedge clk);

    // Three completed jobs for the statistics counters.
    do_reset();
    @(negedge clk);
    set_desc(0, 64'hD00, 64'hE00, 32'd1, 1'b1, 1'b1, 8'h50);
    set_desc(1, 64'hD10, 64'hE10, 32'd2, 1'b1, 1'b1, 8'h52);
    req_valid = 2'b11;
    @(negedge clk);
    set_desc(0, 64'hD01, 64'hE01, 32'd3, 1'b1, 1'b1, 8'h51);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    repeat (60) @(negedge clk);
    #1;
`ifdef DMA_SCHED_STATS_EN
    chk("stats_jobs", stat_jobs, 32'd3);
`else
    chk("stats_jobs_absent", stat_jobs, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
